// File: rtl/rv_inst_pkg.sv
// Shared RV32I constants: loader inst_type codes, base opcodes and the loader FSM states.
package rv_inst_pkg;

    localparam logic [3:0] INST_LOAD  = 4'b0001;
    localparam logic [3:0] INST_STORE = 4'b0010;
    localparam logic [3:0] INST_R     = 4'b0011;
    localparam logic [3:0] INST_I     = 4'b0100;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_WRITE  = 3'd2,
        ST_DONE   = 3'd3,
        ST_FULL   = 3'd4
    } enc_state_e;

endpackage

// File: rtl/inst_word_pack.sv
// Combinational packer: decoded fields -> RV32I word, valid_type low for unsupported classes.
module inst_word_pack
    import rv_inst_pkg::*;
(
    input  logic [3:0]  inst_type,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  func3,
    input  logic [6:0]  func7,
    input  logic [11:0] imm,
    output logic [31:0] word,
    output logic        valid_type
);

    always_comb begin
        word       = '0;
        valid_type = 1'b1;
        case (inst_type)
            INST_R:     word = {func7, rs2, rs1, func3, rd, OP_R};
            INST_I: begin
                // Shifts carry funct7 in the upper immediate bits and a 5-bit shamt.
                if (func3 == 3'b001 || func3 == 3'b101)
                    word = {func7, imm[4:0], rs1, func3, rd, OP_I};
                else
                    word = {imm, rs1, func3, rd, OP_I};
            end
            INST_LOAD:  word = {imm, rs1, func3, rd, OP_LOAD};
            INST_STORE: word = {imm[11:5], rs2, rs1, func3, imm[4:0], OP_STORE};
            default:    valid_type = 1'b0;
        endcase
    end

endmodule

// File: rtl/inst_encoder_loader.sv
// Program loader: encodes field bundles and writes them sequentially into instruction memory.
// Define INST_ENC_CHECKSUM_EN to generate the running-XOR checksum register.
module inst_encoder_loader
    import rv_inst_pkg::*;
#(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [3:0]                   in_inst_type,
    input  logic [4:0]                   in_rd,
    input  logic [4:0]                   in_rs1,
    input  logic [4:0]                   in_rs2,
    input  logic [2:0]                   in_func3,
    input  logic [6:0]                   in_func7,
    input  logic [11:0]                  in_imm,
    input  logic                         in_last,
    output logic                         imem_we,
    input  logic                         imem_ready,
    output logic [31:0]                  imem_addr,
    output logic [31:0]                  imem_wdata,
    output logic [$clog2(DEPTH+1)-1:0]   word_count,
    output logic                         busy,
    output logic                         done,
    output logic                         full,
    output logic                         err_type,
    output logic [31:0]                  checksum
);

    localparam int CW = $clog2(DEPTH + 1);

    enc_state_e    state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          last_q, last_d;
    logic          err_q, err_d;

    logic [31:0]   pack_word;
    logic          pack_valid;
    logic          write_fire;
    logic          at_depth;

    inst_word_pack u_pack (
        .inst_type  (in_inst_type),
        .rd         (in_rd),
        .rs1        (in_rs1),
        .rs2        (in_rs2),
        .func3      (in_func3),
        .func7      (in_func7),
        .imm        (in_imm),
        .word       (pack_word),
        .valid_type (pack_valid)
    );

    // start masks in_ready so a bundle is never taken on the cycle it is discarded.
    assign in_ready   = (state_q == ST_ACCEPT) && !start;
    assign write_fire = (state_q == ST_WRITE) && imem_ready && !start;
    assign at_depth   = (32'(count_q) + 32'd1) == 32'(DEPTH);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        err_d   = err_q;
        if (start) begin
            state_d = ST_ACCEPT;
            addr_d  = BASE_ADDR;
            count_d = '0;
            wdata_d = '0;
            last_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ACCEPT: begin
                    if (in_valid) begin
                        if (pack_valid) begin
                            wdata_d = pack_word;
                            last_d  = in_last;
                            state_d = ST_WRITE;
                        end else begin
                            err_d = 1'b1;
                            if (in_last)
                                state_d = ST_DONE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (imem_ready) begin
                        addr_d  = addr_q + 32'd4;
                        count_d = count_q + CW'(1);
                        if (last_q)
                            state_d = ST_DONE;
                        else if (at_depth)
                            state_d = ST_FULL;
                        else
                            state_d = ST_ACCEPT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= BASE_ADDR;
            count_q <= '0;
            wdata_q <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

`ifdef INST_ENC_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (start)
            checksum_d = '0;
        else if (write_fire)
            checksum_d = checksum_q ^ wdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            checksum_q <= '0;
        else
            checksum_q <= checksum_d;
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign imem_we    = (state_q == ST_WRITE);
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign word_count = count_q;
    assign busy       = (state_q == ST_ACCEPT) || (state_q == ST_WRITE);
    assign done       = (state_q == ST_DONE) || (state_q == ST_FULL);
    assign full       = (state_q == ST_FULL);
    assign err_type   = err_q;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Scoreboard bench for inst_encoder_loader: randomized bundles, queue of expected writes, monitor.
module tb_inst_encoder_loader;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_inst_type = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]  in_func3 = '0;
    logic [6:0]  in_func7 = '0;
    logic [11:0] in_imm = '0;
    logic        in_last = 1'b0;
    logic        imem_we;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_addr, imem_wdata;
    logic [2:0]  word_count;
    logic        busy, done, full, err_type;
    logic [31:0] checksum;

    inst_encoder_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_inst_type(in_inst_type), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_func3(in_func3), .in_func7(in_func7), .in_imm(in_imm), .in_last(in_last),
        .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .word_count(word_count), .busy(busy), .done(done),
        .full(full), .err_type(err_type), .checksum(checksum)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    wr_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          ready_mode = 2;   // 0 random, 1 held low, 2 held high
    logic [31:0] m_addr = BASE;
    logic [31:0] m_cksum = '0;
    int          m_count = 0;
    logic        m_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference encoder built from field weights, independent of bit-slicing.
    function automatic logic [31:0] model_word(input int t, input int rd, input int rs1, input int rs2,
                                               input int f3, input int f7, input int imm);
        int unsigned w;
        w = 0;
        case (t)
            1: w = imm * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12) + rd * (1 << 7) + 3;
            2: w = (imm / 32) * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12)
                   + (imm % 32) * (1 << 7) + 35;
            3: w = f7 * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12) + rd * (1 << 7) + 51;
            4: begin
                if (f3 == 1 || f3 == 5)
                    w = f7 * (1 << 25) + (imm % 32) * (1 << 20);
                else
                    w = imm * (1 << 20);
                w = w + rs1 * (1 << 15) + f3 * (1 << 12) + rd * (1 << 7) + 19;
            end
            default: w = 0;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] exp_cksum();
`ifdef INST_ENC_CHECKSUM_EN
        return m_cksum;
`else
        return 32'd0;
`endif
    endfunction

    // Monitor: every cycle the DUT presents a write it must match the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && imem_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%h@%h required=none", imem_wdata, imem_addr);
                end else begin
                    chk("wr_addr", imem_addr, exp_q[0].addr);
                    chk("wr_data", imem_wdata, exp_q[0].data);
                    if (imem_ready && !start) begin
                        $display("write %h @ %h", imem_wdata, imem_addr);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       imem_ready = ($urandom_range(0, 2) != 0);
                1:       imem_ready = 1'b0;
                default: imem_ready = 1'b1;
            endcase
        end
    end

    task automatic send(input logic [3:0] t, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [11:0] imm, input logic last, input logic [31:0] expw);
        int n;
        @(posedge clk);
        #1;
        in_inst_type = t; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_func3 = f3; in_func7 = f7; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout actual=in_ready_low required=in_ready_high");
        end else if (t >= 4'd1 && t <= 4'd4) begin
            exp_q.push_back('{m_addr, expw});
            m_addr  = m_addr + 32'd4;
            m_count = m_count + 1;
            m_cksum = m_cksum ^ expw;
        end else begin
            m_err = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_rand(input logic last, input logic allow_bad);
        int t, rd, rs1, rs2, f3, f7, imm;
        if (allow_bad && $urandom_range(0, 7) == 0)
            t = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(5, 15));
        else
            t = int'($urandom_range(1, 4));
        rd = int'($urandom_range(0, 31)); rs1 = int'($urandom_range(0, 31));
        rs2 = int'($urandom_range(0, 31)); f3 = int'($urandom_range(0, 7));
        f7 = int'($urandom_range(0, 127)); imm = int'($urandom_range(0, 4095));
        send(4'(t), 5'(rd), 5'(rs1), 5'(rs2), 3'(f3), 7'(f7), 12'(imm), last,
             model_word(t, rd, rs1, rs2, f3, f7, imm));
    endtask

    task automatic do_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        exp_q.delete();
        m_addr = BASE; m_count = 0; m_cksum = '0; m_err = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
        end
        @(negedge clk);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=0 required=1");
        end
    endtask

    task automatic check_status(input string tag, input logic exp_done, input logic exp_full);
        chk({tag, "_done"}, done, exp_done);
        chk({tag, "_full"}, full, exp_full);
        chk({tag, "_busy"}, busy, !exp_done);
        chk({tag, "_count"}, word_count, m_count);
        chk({tag, "_addr"}, imem_addr, m_addr);
        chk({tag, "_err"}, err_type, m_err);
        chk({tag, "_cksum"}, checksum, exp_cksum());
        chk({tag, "_pending"}, exp_q.size(), 0);
        $display("program %s: words=%0d done=%0d full=%0d err=%0d cksum=%h",
                 tag, word_count, done, full, err_type, checksum);
    endtask

    initial begin
        int len;
        logic seen;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_full", full, 0);
        chk("rst_err", err_type, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_count", word_count, 0);
        chk("rst_addr", imem_addr, BASE);
        chk("rst_cksum", checksum, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_in_ready", in_ready, 0);

        // Three-word program from the reference examples.
        do_start();
        ready_mode = 2;
        send(4'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd5, 1'b0, 32'h0050_0093);
        @(negedge clk);
        chk("latency_we", imem_we, 1);
        wait_drain();
        chk("first_count", word_count, 1);
        send(4'd3, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 12'd0, 1'b0, 32'h0020_81B3);
        send(4'd2, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 12'd8, 1'b1, 32'h0020_A423);
        wait_done();
        check_status("p_ir_s", 1'b1, 1'b0);

        do_start();
        send(4'd1, 5'd5, 5'd1, 5'd0, 3'd2, 7'd0, 12'd4, 1'b0, 32'h0040_A283);
        send(4'd4, 5'd1, 5'd1, 5'd0, 3'd5, 7'b0100000, 12'd3, 1'b1, 32'h4030_D093);
        wait_done();
        check_status("p_ld_sh", 1'b1, 1'b0);

        // Backpressure then an unsupported type.
        do_start();
        ready_mode = 1;
        send(4'd4, 5'd7, 5'd2, 5'd0, 3'd0, 7'd0, 12'h7FF, 1'b0, model_word(4, 7, 2, 0, 0, 0, 12'h7FF));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_we", imem_we, 1);
            chk("stall_count", word_count, 0);
        end
        ready_mode = 2;
        wait_drain();
        chk("stall_count_after", word_count, 1);
        send(4'd7, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 12'd1, 1'b0, 32'd0);
        @(negedge clk);
        chk("bad_err", err_type, 1);
        chk("bad_in_ready", in_ready, 1);
        chk("bad_count", word_count, 1);
        send(4'd3, 5'd9, 5'd8, 5'd7, 3'd6, 7'd0, 12'd0, 1'b1, model_word(3, 9, 8, 7, 6, 0, 0));
        wait_done();
        check_status("p_stall_bad", 1'b1, 1'b0);

        // DEPTH reached without in_last.
        do_start();
        ready_mode = 0;
        for (int i = 0; i < DEPTH; i++) send_rand(1'b0, 1'b0);
        wait_done();
        check_status("p_full", 1'b1, 1'b1);
        @(posedge clk);
        #1;
        in_inst_type = 4'd3;
        in_valid = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (in_ready) seen = 1'b1;
        end
        chk("full_reject", seen, 0);
        in_valid = 1'b0;

        // in_last on the DEPTH-th word finishes without full.
        do_start();
        for (int i = 0; i < DEPTH; i++) send_rand(i == DEPTH - 1, 1'b0);
        wait_done();
        check_status("p_last_at_depth", 1'b1, 1'b0);

        // start abandons a pending write.
        do_start();
        ready_mode = 2;
        send_rand(1'b0, 1'b0);
        wait_drain();
        ready_mode = 1;
        send_rand(1'b0, 1'b0);
        @(negedge clk);
        chk("abort_we_before", imem_we, 1);
        do_start();
        @(negedge clk);
        chk("abort_we", imem_we, 0);
        chk("abort_count", word_count, 0);
        chk("abort_addr", imem_addr, BASE);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_cksum", checksum, 0);

        // Random programs with random backpressure and occasional bad types.
        ready_mode = 0;
        for (int p = 0; p < 12; p++) begin
            do_start();
            len = int'($urandom_range(1, DEPTH));
            for (int i = 0; i < len; i++) send_rand(i == len - 1, 1'b1);
            wait_done();
            check_status($sformatf("rand%0d", p), 1'b1, 1'b0);
        end

        // Asynchronous reset mid-write.
        do_start();
        ready_mode = 2;
        send_rand(1'b0, 1'b0);
        wait_drain();
        ready_mode = 1;
        send_rand(1'b0, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_we", imem_we, 0);
        chk("arst_wdata", imem_wdata, 0);
        chk("arst_addr", imem_addr, BASE);
        chk("arst_count", word_count, 0);
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_cksum", checksum, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
